// File: rtl/ddr2_v10_1_seq_ram_pkg.sv
// rtl/ddr2_v10_1_seq_ram_pkg.sv - shared types and defaults for the sequencer RAM arbiter
package ddr2_v10_1_seq_ram_pkg;
   localparam int AW_DEF       = 10;
   localparam int DW_DEF       = 32;
   localparam int MAX_LOCK_DEF = 16;
   localparam int LOCK_CW      = 8;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   typedef enum logic {
      MST0 = 1'b0,
      MST1 = 1'b1
   } mst_t;
endpackage

// File: rtl/ddr2_v10_1_rr_arb2.sv
// rtl/ddr2_v10_1_rr_arb2.sv - two-way round-robin grant with master-0 lock override
module ddr2_v10_1_rr_arb2
   import ddr2_v10_1_seq_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       lock_hold,
   input  logic       force_m1,
   output logic [1:0] grant
);

   mst_t rr_ptr;

   // A held lock keeps master 1 out even on cycles master 0 leaves idle.
   always_comb begin
      grant = 2'b00;
      if (rst)
         grant = 2'b00;
      else if (lock_hold)
         grant = {1'b0, req[0]};
      else if (req == 2'b11)
         grant = (rr_ptr == MST1) ? 2'b10 : 2'b01;
      else
         grant = req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= MST0;
      else if (force_m1)
         rr_ptr <= MST1;
      else if (!lock_hold && req == 2'b11)
         rr_ptr <= (rr_ptr == MST1) ? MST0 : MST1;
   end

endmodule

// File: rtl/ddr2_v10_1_seq_ram_arbiter.sv
// rtl/ddr2_v10_1_seq_ram_arbiter.sv - two-master arbiter for the 1024x32 sequencer RAM
// Optional master-1 write protection: DDR2_V10_1_SEQ_RAM_ARB_PROT_EN
module ddr2_v10_1_seq_ram_arbiter
   import ddr2_v10_1_seq_ram_pkg::*;
#(
   parameter int            AW         = AW_DEF,
   parameter int            DW         = DW_DEF,
   parameter int            MAX_LOCK   = MAX_LOCK_DEF,
   parameter logic [AW-1:0] PROT_LIMIT = 10'h100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   m0_address,
   input  logic [DW/8-1:0] m0_byteenable,
   input  logic            m0_read,
   input  logic            m0_write,
   input  logic [DW-1:0]   m0_writedata,
   output logic            m0_waitrequest,
   output logic [DW-1:0]   m0_readdata,
   output logic            m0_readdatavalid,
   input  logic            m0_lock,
   input  logic [AW-1:0]   m1_address,
   input  logic [DW/8-1:0] m1_byteenable,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW-1:0]   m1_writedata,
   output logic            m1_waitrequest,
   output logic [DW-1:0]   m1_readdata,
   output logic            m1_readdatavalid,
   output logic [AW-1:0]   ram_address,
   output logic [DW/8-1:0] ram_byteenable,
   output logic            ram_chipselect,
   output logic            ram_write,
   output logic [DW-1:0]   ram_writedata,
   output logic            ram_clken,
   input  logic [DW-1:0]   ram_readdata,
   output logic            prot_err
);

   localparam logic [LOCK_CW-1:0] MAX_LOCK_C = LOCK_CW'(MAX_LOCK);
   localparam logic               LOCK_ONE   = (MAX_LOCK == 1);
`ifdef DDR2_V10_1_SEQ_RAM_ARB_PROT_EN
   localparam logic PROT_ON = 1'b1;
`else
   localparam logic PROT_ON = 1'b0;
`endif

   lock_state_t        state;
   logic [LOCK_CW-1:0] lock_cnt;
   logic               relock_block;
   logic               rd_pend;
   mst_t               rd_owner;

   logic [1:0]         req;
   logic [1:0]         grant;
   logic               lock_hold;
   logic               lock_enter;
   logic               lock_step;
   logic               force_rel;
   logic [LOCK_CW-1:0] cnt_inc;
   logic               sel_m1;
   logic               sel_write;
   logic               sel_read;
   logic               rd_issue;
   logic               prot_drop;

   assign req       = {m1_read | m1_write, m0_read | m0_write};
   assign lock_hold = (state == LOCKED) && m0_lock;

   ddr2_v10_1_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (reset),
      .req       (req),
      .lock_hold (lock_hold),
      .force_m1  (force_rel),
      .grant     (grant)
   );

   assign m0_waitrequest = reset | (req[0] & ~grant[0]);
   assign m1_waitrequest = reset | (req[1] & ~grant[1]);

   // Forced release fires on the grant that brings the count to MAX_LOCK,
   // so the very next cycle already arbitrates toward master 1.
   assign cnt_inc    = lock_cnt + 1'b1;
   assign lock_enter = (state == UNLOCKED) && grant[0] && m0_lock && !relock_block;
   assign lock_step  = (state == LOCKED) && grant[0] && m0_lock;
   assign force_rel  = (lock_enter && LOCK_ONE) || (lock_step && (cnt_inc == MAX_LOCK_C));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= UNLOCKED;
         lock_cnt     <= '0;
         relock_block <= 1'b0;
      end else begin
         if (!m0_lock)
            relock_block <= 1'b0;
         else if (force_rel)
            relock_block <= 1'b1;
         case (state)
            UNLOCKED: begin
               if (lock_enter) begin
                  lock_cnt <= LOCK_CW'(1);
                  state    <= force_rel ? UNLOCKED : LOCKED;
               end
            end
            LOCKED: begin
               if (!m0_lock)
                  state <= UNLOCKED;
               else if (grant[0]) begin
                  lock_cnt <= cnt_inc;
                  if (force_rel)
                     state <= UNLOCKED;
               end
            end
            default: state <= UNLOCKED;
         endcase
      end
   end

   assign sel_m1    = grant[1];
   assign sel_write = sel_m1 ? m1_write : m0_write;
   assign sel_read  = sel_m1 ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
   assign rd_issue  = (|grant) & sel_read;
   assign prot_drop = PROT_ON & grant[1] & m1_write & (m1_address < PROT_LIMIT);

   assign ram_address    = sel_m1 ? m1_address    : m0_address;
   assign ram_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
   assign ram_writedata  = sel_m1 ? m1_writedata  : m0_writedata;
   assign ram_chipselect = |grant;
   assign ram_write      = (|grant) & sel_write & ~prot_drop;
   assign ram_clken      = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend  <= 1'b0;
         rd_owner <= MST0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue)
            rd_owner <= sel_m1 ? MST1 : MST0;
      end
   end

   assign m0_readdatavalid = rd_pend && (rd_owner == MST0);
   assign m1_readdatavalid = rd_pend && (rd_owner == MST1);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

`ifdef DDR2_V10_1_SEQ_RAM_ARB_PROT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prot_err <= 1'b0;
      else
         prot_err <= prot_drop;
   end
`else
   assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_v10_1_seq_ram_arbiter.sv
// tb/tb_ddr2_v10_1_seq_ram_arbiter.sv - directed self-checking bench with a behavioural RAM
module tb_ddr2_v10_1_seq_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write, m0_lock;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [9:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata, ram_readdata;
   logic        prot_err;

   logic [31:0] mem [0:1023];
   logic [7:0]  lk_m1g = 8'b0101_0000;
   int          checks = 0;
   int          failures = 0;

`ifdef DDR2_V10_1_SEQ_RAM_ARB_PROT_EN
   localparam logic PROT = 1'b1;
`else
   localparam logic PROT = 1'b0;
`endif

   ddr2_v10_1_seq_ram_arbiter #(.MAX_LOCK(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m0_lock          (m0_lock),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .ram_address      (ram_address),
      .ram_byteenable   (ram_byteenable),
      .ram_chipselect   (ram_chipselect),
      .ram_write        (ram_write),
      .ram_writedata    (ram_writedata),
      .ram_clken        (ram_clken),
      .ram_readdata     (ram_readdata),
      .prot_err         (prot_err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] <= 32'hA500_0000 | 32'(i);
   end

   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write)
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b])
                  mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         ram_readdata <= mem[ram_address];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic idle();
      m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = 4'hF;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle();
      m0_read = 1; m1_read = 1;
      repeat (2) @(posedge clk);
      smp();
      check("rst_wait0", 32'(m0_waitrequest), 32'd1);
      check("rst_wait1", 32'(m1_waitrequest), 32'd1);
      check("rst_cs", 32'(ram_chipselect), 32'd0);
      check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
      check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
      check("rst_prot", 32'(prot_err), 32'd0);
      check("rst_clken", 32'(ram_clken), 32'd1);
      nxt();
      reset = 1'b0;
      idle();

      m1_read = 1; m1_address = 10'h005;
      smp();
      check("t1_wait1", 32'(m1_waitrequest), 32'd0);
      check("t1_addr", 32'(ram_address), 32'h005);
      nxt(); idle();
      smp();
      check("t1_rdv1", 32'(m1_readdatavalid), 32'd1);
      check("t1_data1", m1_readdata, 32'hA500_0005);
      check("t1_rdv0", 32'(m0_readdatavalid), 32'd0);

      nxt();
      m0_write = 1; m0_address = 10'h020; m0_writedata = 32'h1111_1111;
      m1_write = 1; m1_address = 10'h030; m1_writedata = 32'h2222_2222;
      for (int i = 0; i < 4; i++) begin
         smp();
         check("rr_wait0", 32'(m0_waitrequest), 32'(i[0]));
         check("rr_wait1", 32'(m1_waitrequest), 32'(!i[0]));
         check("rr_addr", 32'(ram_address), i[0] ? 32'h030 : 32'h020);
         check("rr_wen", 32'(ram_write), 32'd1);
         nxt();
      end
      idle();

      m0_write = 1; m0_address = 10'h010; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'b0011;
      smp();
      check("be_wait0", 32'(m0_waitrequest), 32'd0);
      nxt(); idle();
      m0_read = 1; m0_address = 10'h010;
      smp();
      nxt(); idle();
      smp();
      check("be_rdv0", 32'(m0_readdatavalid), 32'd1);
      check("be_data", m0_readdata, 32'hA500_BEEF);

      nxt();
      m0_read = 1; m0_address = 10'h020; m1_read = 1; m1_address = 10'h040;
      smp();
      check("pl_a_wait0", 32'(m0_waitrequest), 32'd0);
      check("pl_a_wait1", 32'(m1_waitrequest), 32'd1);
      nxt();
      m0_address = 10'h030;
      smp();
      check("pl_b_wait0", 32'(m0_waitrequest), 32'd1);
      check("pl_b_wait1", 32'(m1_waitrequest), 32'd0);
      check("pl_b_rdv0", 32'(m0_readdatavalid), 32'd1);
      check("pl_b_data0", m0_readdata, 32'h1111_1111);
      nxt();
      m1_read = 0;
      smp();
      check("pl_c_wait0", 32'(m0_waitrequest), 32'd0);
      check("pl_c_rdv1", 32'(m1_readdatavalid), 32'd1);
      check("pl_c_rdv0", 32'(m0_readdatavalid), 32'd0);
      check("pl_c_data1", m1_readdata, 32'hA500_0040);
      nxt(); idle();
      smp();
      check("pl_d_rdv0", 32'(m0_readdatavalid), 32'd1);
      check("pl_d_rdv1", 32'(m1_readdatavalid), 32'd0);
      check("pl_d_data0", m0_readdata, 32'h2222_2222);

      nxt();
      m0_lock = 1;
      m0_write = 1; m0_address = 10'h050; m0_writedata = 32'h3333_3333;
      m1_write = 1; m1_address = 10'h060; m1_writedata = 32'h4444_4444;
      for (int i = 0; i < 8; i++) begin
         smp();
         check("lk_wait0", 32'(m0_waitrequest), 32'(lk_m1g[i]));
         check("lk_wait1", 32'(m1_waitrequest), 32'(!lk_m1g[i]));
         nxt();
      end
      m0_lock = 0;
      smp();
      check("lk_drop_wait1", 32'(m1_waitrequest), 32'd0);
      nxt();
      m0_lock = 1;
      smp();
      check("lk_relock_wait0", 32'(m0_waitrequest), 32'd0);
      nxt();
      smp();
      check("lk_hold_wait1", 32'(m1_waitrequest), 32'd1);
      nxt();
      m0_lock = 0;
      smp();
      check("lk_rel_wait1", 32'(m1_waitrequest), 32'd0);
      nxt(); idle();

      m0_read = 1; m0_address = 10'h010;
      smp();
      check("rr_rst_wait0", 32'(m0_waitrequest), 32'd0);
      nxt();
      reset = 1; m1_write = 1;
      smp();
      check("mrst_rdv0", 32'(m0_readdatavalid), 32'd0);
      check("mrst_wait0", 32'(m0_waitrequest), 32'd1);
      check("mrst_wait1", 32'(m1_waitrequest), 32'd1);
      check("mrst_cs", 32'(ram_chipselect), 32'd0);
      nxt();
      reset = 0; idle();
      smp();
      check("mrst_post_rdv0", 32'(m0_readdatavalid), 32'd0);

      nxt();
      m1_write = 1; m1_address = 10'h0FF; m1_writedata = 32'h1234_5678;
      smp();
      check("pr_wait1", 32'(m1_waitrequest), 32'd0);
      check("pr_wen", 32'(ram_write), 32'(!PROT));
      nxt();
      m1_address = 10'h100; m1_writedata = 32'hCAFE_F00D;
      smp();
      check("pr_err", 32'(prot_err), 32'(PROT));
      check("pr_ok_wait1", 32'(m1_waitrequest), 32'd0);
      check("pr_ok_wen", 32'(ram_write), 32'd1);
      nxt(); idle();
      m0_read = 1; m0_address = 10'h0FF;
      smp();
      check("pr_ok_err", 32'(prot_err), 32'd0);
      nxt();
      m0_address = 10'h100;
      smp();
      check("pr_rb_ff", m0_readdata, PROT ? 32'hA500_00FF : 32'h1234_5678);
      nxt(); idle();
      smp();
      check("pr_rb_100", m0_readdata, 32'hCAFE_F00D);
      check("pr_rb_rdv0", 32'(m0_readdatavalid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ddr2_v10_1_seq_ram_arbiter.md
Name: ddr2_v10_1_seq_ram_arbiter

Overview:
Shares the 1024x32 single-port sequencer RAM (byte-enabled, 1-cycle read latency, unregistered output) between two Avalon-MM masters.
- Master 0: sequencer CPU data port.
- Master 1: debug/calibration-readback port.
Round-robin arbitration with one RAM access per cycle. Master 0 may lock the RAM for read-modify-write sequences; a bounded lock counter forces release.

Parameters:
AW, 10, RAM word-address width
DW, 32, data width; byte-enable width is DW/8
MAX_LOCK, 16, max consecutive granted cycles master 0 may hold a lock (1..255)
PROT_LIMIT, 10'h100, word addresses below this are write-protected from master 1 (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
mN_address  in  AW  master N (N=0,1) word address
mN_byteenable  in  DW/8  master N byte lanes
mN_read  in  1  master N read request
mN_write  in  1  master N write request
mN_writedata  in  DW  master N write data
mN_waitrequest  out  1  request not accepted this cycle
mN_readdata  out  DW  read data
mN_readdatavalid  out  1  one-cycle strobe marking valid readdata
m0_lock  in  1  hold grant across consecutive m0 transfers
ram_address  out  AW  to RAM
ram_byteenable  out  DW/8  to RAM
ram_chipselect  out  1  to RAM
ram_write  out  1  to RAM
ram_writedata  out  DW  to RAM
ram_clken  out  1  tied 1; RAM always enabled
ram_readdata  in  DW  from RAM, valid 1 cycle after a read address is presented
prot_err  out  1  pulse on a dropped protected write (optional feature only; otherwise tied 0)

Behaviour:
- Request: reqN = mN_read | mN_write. Read and write both high on one master is illegal; write wins and the read is ignored.
- Grant is combinational each cycle from reqN, the registered rr_ptr and the lock state. Only one grant per cycle.
  - Only one requester: it wins.
  - Both requesting: the master rr_ptr points to wins, then rr_ptr flips to the other master.
  - Lock held: master 0 wins, whatever rr_ptr says.
- mN_waitrequest = reqN & ~grantN. While reset is high, both waitrequests are forced to 1.
- RAM outputs are a combinational mux of the granted master's signals.
  - ram_chipselect = any grant.
  - ram_write = granted master's write.
  - With no grant, ram_chipselect=0 and ram_write=0; address/data are don't-care (drive m0's values).
- Read return, latency exactly 1 cycle:
  - A granted read registers rd_pend=1 and rd_owner=N.
  - Next cycle: mN_readdatavalid = rd_pend & (rd_owner==N), and mN_readdata = ram_readdata.
  - Back-to-back reads are fully pipelined, one per cycle, possibly alternating owners.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED when master 0 is granted with m0_lock=1; lock_cnt loads 1.
  - In LOCKED, each cycle with m0 granted increments lock_cnt. Idle cycles with m0_lock still high keep LOCKED without counting.
  - LOCKED -> UNLOCKED when m0_lock=0, or when lock_cnt==MAX_LOCK. On a forced release, rr_ptr is set to master 1, and master 0 cannot re-lock until it has dropped m0_lock for at least one cycle (relock_block flag).
- Reset values: rr_ptr=0, state=UNLOCKED, lock_cnt=0, relock_block=0, rd_pend=0, rd_owner=0. Hence both readdatavalid=0 and prot_err=0.
- Reset asserted mid-read: the pending readdatavalid is suppressed. Requests presented during reset are not accepted.
- Write to an address equal to the previous cycle's read address: the read returns old data (RAM read-during-write is don't-care; masters must not rely on it).

Optional Feature:
DDR2_V10_1_SEQ_RAM_ARB_PROT_EN
- Defined: a master-1 write with address < PROT_LIMIT is still granted and acknowledged (waitrequest low, so the master does not hang), but ram_write is forced to 0. prot_err pulses high for that cycle, registered one cycle later.
- Undefined: no address comparison; prot_err tied 0; master-1 writes reach the RAM unchanged.

Decomposition:
- Shared package ddr2_v10_1_seq_ram_pkg holds:
  - AW/DW defaults;
  - the lock FSM state typedef (UNLOCKED, LOCKED);
  - the master-index typedef;
  - the MAX_LOCK default.
- One sub-module, ddr2_v10_1_rr_arb2: 2-way round-robin grant with a lock override. It holds rr_ptr and outputs grant[1:0].
- The top level holds the lock FSM, the read-return pipeline and the RAM mux.

Test Plan:
- After reset, m1 reads 0x005 alone -> m1_waitrequest=0 that cycle; next cycle m1_readdatavalid=1 with the RAM contents; m0_readdatavalid stays 0.
- m0 and m1 both write every cycle for 4 cycles -> grants alternate m0,m1,m0,m1 starting with m0; each waitrequest is high on alternate cycles.
- m0 writes 0xDEADBEEF to 0x010 with byteenable 4'b0011, then reads 0x010 -> returns 0xXXXXBEEF, with the upper bytes keeping their prior value.
- m0_lock=1 with continuous m0 and m1 requests, MAX_LOCK=4 -> m0 is granted 4 cycles, then m1 is granted; m0 cannot relock until m0_lock has dropped.
- Reset asserted the cycle after a granted m0 read -> m0_readdatavalid stays 0; both waitrequests are 1 during reset.
- With DDR2_V10_1_SEQ_RAM_ARB_PROT_EN: m1 writes 0x12345678 to 0x0FF -> acknowledged, prot_err pulses once, readback shows the old value; a write to 0x100 succeeds with no prot_err.
